// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel receiver with comma alignment. It hunts for COMMA on any bit
// phase, locks to that byte boundary, and after BC_COUNT aligned commas it delivers data bytes.
module serial_paralelo_sync #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BCW = (BC_COUNT < 2) ? 1 : $clog2(BC_COUNT + 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BC_COUNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ALIGNED = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t         state;
  logic [6:0]     sr;
  logic [2:0]     cnt;
  logic [BCW-1:0] bc_cnt;
  logic [7:0]     word;
  logic [BCW-1:0] bc_next;
  logic           boundary;
  logic           is_comma;

  // Candidate byte: the seven previous bits plus the bit arriving on this edge
  assign word     = {sr, data_in};
  assign is_comma = (word == COMMA);
  assign boundary = (cnt == 3'd7);
  assign bc_next  = bc_cnt + BCW'(1);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= 7'd0;
      cnt       <= 3'd0;
      bc_cnt    <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= word[6:0];
      valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          cnt    <= 3'd0;
          bc_cnt <= '0;
          if (is_comma) begin
            bc_cnt <= BCW'(1);
            if (BC_LAST <= BCW'(1)) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGNED;
            end
          end
        end

        ALIGNED: begin
          cnt <= cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_next;
              if (bc_next == BC_LAST) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Lost alignment: hunt again on every bit phase from the next edge
              bc_cnt <= '0;
              cnt    <= 3'd0;
              state  <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          cnt <= cnt + 3'd1;
          if (boundary && !is_comma) begin
            data_out  <= word;
            valid_out <= 1'b1;
          end
        end

        default: begin
          state  <= SEARCH;
          cnt    <= 3'd0;
          bc_cnt <= '0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
